mem_access_unit: RTL
====================

# mem_access_unit

Request/response front end that sits directly upstream of the processor's `memory` block. It accepts one load or store per handshake from the core and drives the memory's `readwriteN`/`address`/`data_in` so that exactly one negative clock edge sees each access. It captures `data_out` on the following rising edge and returns it with an error flag. Stores to the read-only memory-mapped input window (F9..FF) are blocked and reported.

## Interface
Parameters:
- RO_BASE, 8'hF9, first address of the read-only input window; the window runs from RO_BASE to 8'hFF inclusive.

Ports:
- Clocking: one clock, `clk`. Reset is synchronous and active-high, named `rst`; polarity and synchronicity are fixed.
- clk  in  1  system clock; the memory acts on its negedge, this block on its posedge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  core presents a request
- req_ready  out  1  block can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  8  byte address
- req_wdata  in  8  store data
- resp_valid  out  1  response available
- resp_ready  in  1  core accepts the response
- resp_rdata  out  8  load data; 0 for stores
- resp_err  out  1  store to the read-only window was blocked
- mem_readwriteN  out  1  drives memory `readwriteN`; 0 = write
- mem_address  out  8  drives memory `address`
- mem_data_in  out  8  drives memory `data_in`
- mem_data_out  in  8  from memory `data_out`

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- req_ready = (state == IDLE). It is combinational from state only.
- IDLE, on posedge with req_valid=1:
  - Register mem_address ← req_addr and mem_data_in ← req_wdata.
  - Register an internal is_write ← req_write.
  - mem_readwriteN ← ~(req_write && req_addr < RO_BASE).
  - err_pending ← req_write && req_addr >= RO_BASE.
  - Go to ACCESS.
- ACCESS (exactly one cycle):
  - On posedge, force mem_readwriteN ← 1.
  - For a load, resp_rdata ← mem_data_out; for a store, resp_rdata ← 0.
  - resp_err ← err_pending; resp_valid ← 1; go to RESP.
- RESP:
  - resp_valid, resp_rdata and resp_err hold stable until a posedge with resp_ready=1.
  - On that edge: resp_valid ← 0, resp_err ← 0; go to IDLE.
- Request fields are ignored outside IDLE. A request arriving during RESP waits; req_ready=0 there.
- mem_address and mem_data_in hold their last values between accesses. mem_readwriteN is 1 in every state except ACCESS of a permitted store.
- A blocked store drives no write strobe. The memory therefore performs a read at that negedge, and the result is discarded.
- A load from the read-only window is legal and returns the live input value.
- A store to 8'hF8 is permitted; it updates `outdataio`.

## Timing
- Reset values: req_ready=1 (IDLE), resp_valid=0, resp_rdata=0, resp_err=0, mem_readwriteN=1, mem_address=0, mem_data_in=0.
- Access sequence, with the request accepted at posedge k:
  - Memory address, data and strobe are stable after posedge k.
  - The memory acts at the negedge between k and k+1.
  - resp_valid=1 after posedge k+1 (latency 1 cycle).
- Exactly one negedge sees mem_readwriteN=0 per permitted store. No write strobe exists outside ACCESS.
- With resp_ready held at 1, the response completes at posedge k+2. Next accept is at k+3, giving a peak throughput of 1 access per 3 cycles.
- Reset mid-operation: at the rst posedge the block enters IDLE and all outputs take their reset values. Any write strobe already seen at the preceding negedge remains committed in memory. No response is issued for an aborted access.
- Simultaneous resp_ready and req_valid during RESP: only the response completes; the request is accepted in the next cycle.
- rst takes priority over every handshake.

## Test plan
- Store 8'h5A to 8'h10, then load 8'h10: the store response has resp_err=0 and resp_rdata=0. The load response has resp_rdata=8'h5A, with resp_valid rising one cycle after accept.
- Store 8'hC3 to 8'hF8: `outdataio`=8'hC3 after the ACCESS negedge. mem_readwriteN is low for exactly one cycle.
- Store 8'h77 to 8'hFA with indata2=8'h12: resp_err=1 and mem_readwriteN never goes low. A following load of 8'hFA returns 8'h12.
- Load 8'h10 while resp_ready is held 0 for 4 cycles: resp_valid, resp_rdata=8'h5A and resp_err stay stable. req_ready=0 throughout, and a second req_valid is not accepted until RESP exits.
- Back-to-back stores to 8'h00..8'h03 with resp_ready=1: one accept every 3 cycles and 4 write strobes total. Read-back returns all four values.
- Assert rst during ACCESS of a store to 8'h20: the next posedge gives IDLE, resp_valid=0, mem_readwriteN=1, and no response is issued. req_ready=1 after reset releases.

Source files
------------

// File: rtl/mem_access_unit.sv
// Request/response front end for the processor memory: one load or store per handshake,
// presented to the memory for exactly one negedge, with stores to the read-only input window blocked.
module mem_access_unit #(
  parameter logic [7:0] RO_BASE = 8'hF9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic [7:0] resp_rdata,
  output logic       resp_err,
  output logic       mem_readwriteN,
  output logic [7:0] mem_address,
  output logic [7:0] mem_data_in,
  input  logic [7:0] mem_data_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       rwn_q, rwn_d;
  logic       is_write_q, is_write_d;
  logic       err_pending_q, err_pending_d;
  logic [7:0] rdata_q, rdata_d;
  logic       err_q, err_d;
  logic       valid_q, valid_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      addr_q        <= 8'h00;
      wdata_q       <= 8'h00;
      rwn_q         <= 1'b1;
      is_write_q    <= 1'b0;
      err_pending_q <= 1'b0;
      rdata_q       <= 8'h00;
      err_q         <= 1'b0;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rwn_q         <= rwn_d;
      is_write_q    <= is_write_d;
      err_pending_q <= err_pending_d;
      rdata_q       <= rdata_d;
      err_q         <= err_d;
      valid_q       <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
  end

  // The write strobe is only ever raised for one cycle, and never for the read-only window.
  always_comb begin
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rwn_d         = rwn_q;
    is_write_d    = is_write_q;
    err_pending_d = err_pending_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    valid_d       = valid_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d        = req_addr;
          wdata_d       = req_wdata;
          is_write_d    = req_write;
          rwn_d         = ~(req_write && (req_addr < RO_BASE));
          err_pending_d = req_write && (req_addr >= RO_BASE);
        end
      end
      ACCESS: begin
        rwn_d   = 1'b1;
        rdata_d = is_write_q ? 8'h00 : mem_data_out;
        err_d   = err_pending_q;
        valid_d = 1'b1;
      end
      RESP: begin
        if (resp_ready) begin
          valid_d = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign resp_valid     = valid_q;
  assign resp_rdata     = rdata_q;
  assign resp_err       = err_q;
  assign mem_readwriteN = rwn_q;
  assign mem_address    = addr_q;
  assign mem_data_in    = wdata_q;

endmodule
